// File: rtl/attempt_tracker.sv
// rtl/attempt_tracker.sv - failed-attempt tracker with timed unlock, lockout and absence clear
module attempt_tracker #(
    parameter int ABSENT_CYCLES = 50_000_000,
    parameter int OPEN_CYCLES   = 150_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       presence,
    input  logic       try_valid,
    input  logic       try_ok,
    output logic [1:0] attempts,
    output logic       unlock,
    output logic       locked
);

    localparam int AW = $clog2(ABSENT_CYCLES + 1);
    localparam int OW = $clog2(OPEN_CYCLES + 1);

    localparam logic [AW-1:0] ABSENT_SAT  = AW'(ABSENT_CYCLES);
    localparam logic [AW-1:0] ABSENT_TRIG = AW'(ABSENT_CYCLES - 1);
    localparam logic [OW-1:0] OPEN_LOAD   = OW'(OPEN_CYCLES);
    localparam logic [OW-1:0] OPEN_ONE    = OW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        OPEN   = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      attempts_next;
    logic            unlock_next;
    logic            locked_next;
    logic [OW-1:0]   open_timer;
    logic [OW-1:0]   open_timer_next;
    logic [AW-1:0]   absent_cnt;
    logic            absent_timeout;

    // Fires once per absence: the counter saturates one past the trigger value,
    // so it cannot match again until presence clears it.
    assign absent_timeout = !presence && (absent_cnt == ABSENT_TRIG);

    // Consecutive-absence counter, cleared by presence, saturating at ABSENT_CYCLES
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            absent_cnt <= '0;
        end else if (presence) begin
            absent_cnt <= '0;
        end else if (absent_cnt != ABSENT_SAT) begin
            absent_cnt <= absent_cnt + AW'(1);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            attempts   <= 2'd0;
            unlock     <= 1'b0;
            locked     <= 1'b0;
            open_timer <= '0;
        end else begin
            state      <= state_next;
            attempts   <= attempts_next;
            unlock     <= unlock_next;
            locked     <= locked_next;
            open_timer <= open_timer_next;
        end
    end

    // Next-state and next-output decisions
    always_comb begin
        state_next      = state;
        attempts_next   = attempts;
        unlock_next     = unlock;
        locked_next     = locked;
        open_timer_next = open_timer;

        case (state)
            IDLE: begin
                attempts_next   = 2'd0;
                unlock_next     = 1'b0;
                locked_next     = 1'b0;
                open_timer_next = '0;
                if (presence) begin
                    state_next = ARMED;
                end
            end

            ARMED: begin
                unlock_next = 1'b0;
                locked_next = 1'b0;
                // Absence wins over a strobe in the same cycle so a walk-away
                // cannot be turned into an extra failure.
                if (absent_timeout) begin
                    state_next    = IDLE;
                    attempts_next = 2'd0;
                end else if (try_valid) begin
                    if (try_ok) begin
                        state_next      = OPEN;
                        attempts_next   = 2'd0;
                        unlock_next     = 1'b1;
                        open_timer_next = OPEN_LOAD;
                    end else if (attempts >= 2'd2) begin
                        state_next    = LOCKED;
                        attempts_next = 2'd3;
                        locked_next   = 1'b1;
                    end else begin
                        attempts_next = attempts + 2'd1;
                    end
                end
            end

            OPEN: begin
                attempts_next = 2'd0;
                locked_next   = 1'b0;
                // Timer counts OPEN_CYCLES..1 while unlock is visible; the
                // cycle holding 1 is the last one with unlock high.
                if (open_timer <= OPEN_ONE) begin
                    unlock_next     = 1'b0;
                    open_timer_next = '0;
                    state_next      = presence ? ARMED : IDLE;
                end else begin
                    unlock_next     = 1'b1;
                    open_timer_next = open_timer - OPEN_ONE;
                end
            end

            LOCKED: begin
                unlock_next   = 1'b0;
                attempts_next = 2'd3;
                locked_next   = 1'b1;
                // Only a completed absence releases a lockout; codes are ignored.
                if (absent_timeout) begin
                    state_next    = IDLE;
                    attempts_next = 2'd0;
                    locked_next   = 1'b0;
                end
            end

            default: begin
                state_next      = IDLE;
                attempts_next   = 2'd0;
                unlock_next     = 1'b0;
                locked_next     = 1'b0;
                open_timer_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_attempt_tracker.sv
// tb/tb_attempt_tracker.sv - directed plus randomized check of attempt_tracker against a behavioural model
module tb_attempt_tracker;

    localparam int ABSENT = 8;
    localparam int OPENC  = 4;

    logic       clk;
    logic       rst_n;
    logic       presence;
    logic       try_valid;
    logic       try_ok;
    logic [1:0] attempts;
    logic       unlock;
    logic       locked;

    int checks = 0;
    int errors = 0;

    // Reference model: user engagement, failure count, unlock time left, absence run
    bit m_engaged;
    int m_att;
    int m_open_left;
    int m_absent_run;

    attempt_tracker #(
        .ABSENT_CYCLES(ABSENT),
        .OPEN_CYCLES  (OPENC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .presence (presence),
        .try_valid(try_valid),
        .try_ok   (try_ok),
        .attempts (attempts),
        .unlock   (unlock),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_engaged    = 1'b0;
        m_att        = 0;
        m_open_left  = 0;
        m_absent_run = 0;
    endtask

    // One clock of the rules: the user counts as gone on the ABSENT-th
    // consecutive absent cycle, and only at that moment.
    task automatic model_step(input bit p, input bit tv, input bit tok);
        bit gone_now;
        gone_now = !p && (m_absent_run + 1 == ABSENT);
        if (p) m_absent_run = 0;
        else if (m_absent_run < ABSENT) m_absent_run++;

        if (m_open_left > 0) begin
            m_open_left--;
            if (m_open_left == 0) m_engaged = p;
        end else if (!m_engaged) begin
            if (p) m_engaged = 1'b1;
        end else if (gone_now) begin
            m_engaged = 1'b0;
            m_att     = 0;
        end else if (m_att == 3) begin
            // lockout: nothing but absence helps
        end else if (tv && tok) begin
            m_att       = 0;
            m_open_left = OPENC;
        end else if (tv) begin
            m_att++;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_attempts"}, int'(attempts), m_att);
        check({tag, "_unlock"},   int'(unlock),   (m_open_left > 0) ? 1 : 0);
        check({tag, "_locked"},   int'(locked),   (m_att == 3) ? 1 : 0);
    endtask

    task automatic cycle(input bit p, input bit tv, input bit tok, input string tag);
        presence  = p;
        try_valid = tv;
        try_ok    = tok;
        @(posedge clk);
        model_step(p, tv, tok);
        #1;
        compare_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #1;
        rst_n = 1'b0;
        #2;
        model_reset();
        check({tag, "_rst_attempts"}, int'(attempts), 0);
        check({tag, "_rst_unlock"},   int'(unlock),   0);
        check({tag, "_rst_locked"},   int'(locked),   0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int run_left;
        bit rp;
        rst_n     = 1'b0;
        presence  = 1'b0;
        try_valid = 1'b0;
        try_ok    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_attempts", int'(attempts), 0);
        check("reset_unlock",   int'(unlock),   0);
        check("reset_locked",   int'(locked),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: three failures lead to lockout
        cycle(1, 0, 0, "t1_arm");
        for (int k = 1; k <= 3; k++) begin
            cycle(1, 1, 0, "t1_fail");
            check("t1_att_step", int'(attempts), k);
            cycle(1, 0, 0, "t1_gap");
            cycle(1, 0, 0, "t1_gap");
        end
        check("t1_locked", int'(locked), 1);
        check("t1_unlock", int'(unlock), 0);

        // 2: correct code cannot clear lockout; absence does
        cycle(1, 1, 1, "t2_ok_in_lock");
        check("t2_still3", int'(attempts), 3);
        for (int k = 0; k < ABSENT; k++) cycle(0, 0, 0, "t2_absent");
        check("t2_cleared_att", int'(attempts), 0);
        check("t2_cleared_lock", int'(locked), 0);
        cycle(0, 1, 0, "t2_idle_ignores");
        check("t2_idle_att", int'(attempts), 0);

        // 3: fail, then correct code opens for OPENC cycles
        cycle(1, 0, 0, "t3_arm");
        cycle(1, 1, 0, "t3_fail");
        cycle(1, 1, 1, "t3_ok");
        check("t3_open_att", int'(attempts), 0);
        check("t3_open_unlock", int'(unlock), 1);
        cycle(1, 1, 0, "t3_fail_in_open");
        cycle(1, 0, 0, "t3_open");
        cycle(1, 0, 0, "t3_open");
        check("t3_last_unlock", int'(unlock), 1);
        cycle(1, 0, 0, "t3_close");
        check("t3_closed", int'(unlock), 0);
        cycle(1, 1, 0, "t3_armed_fail");
        check("t3_armed_att", int'(attempts), 1);

        // 4: short absence keeps count; timeout beats simultaneous failure
        cycle(1, 1, 0, "t4_fail2");
        for (int k = 0; k < ABSENT - 1; k++) cycle(0, 0, 0, "t4_short");
        cycle(1, 0, 0, "t4_back");
        check("t4_kept", int'(attempts), 2);
        for (int k = 0; k < ABSENT - 1; k++) cycle(0, 0, 0, "t4_long");
        cycle(0, 1, 0, "t4_timeout_fail");
        check("t4_timeout_wins", int'(attempts), 0);

        // 5: asynchronous reset in OPEN and in LOCKED
        cycle(1, 0, 0, "t5_arm");
        cycle(1, 1, 1, "t5_open");
        async_reset("t5_open");
        cycle(0, 1, 0, "t5_idle");
        cycle(1, 0, 0, "t5_arm2");
        for (int k = 0; k < 3; k++) cycle(1, 1, 0, "t5_fail");
        check("t5_locked_before", int'(locked), 1);
        async_reset("t5_lock");
        cycle(1, 1, 0, "t5_after");

        // Randomized runs of presence with random strobes
        run_left = 0;
        rp = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (run_left == 0) begin
                rp = $urandom_range(0, 1);
                run_left = $urandom_range(1, 12);
            end
            run_left--;
            cycle(rp, ($urandom_range(0, 3) == 0), $urandom_range(0, 1), "rnd");
            if ($urandom_range(0, 999) == 0) async_reset("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/attempt_tracker.md
Name: attempt_tracker

Overview:
Access-control attempt tracker that produces the 2-bit failed-attempt count consumed by the buzzer driver (alarm sounds at count 3). It consumes password-check results from the keypad/compare logic and presence from the ultrasonic detector. It grants a timed unlock on a correct entry and latches a lockout after three failures. The count clears only when the user has been absent for a configurable time.

Parameters:
ABSENT_CYCLES, 50_000_000, consecutive cycles with presence=0 required to declare the user gone (1 s at 50 MHz); minimum 2.
OPEN_CYCLES, 150_000_000, cycles unlock stays asserted after a correct entry; minimum 1.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
presence  input  1  ultrasonic detector: 1 = object in range (synchronous to clk)
try_valid  input  1  one-cycle strobe: an entry has been checked
try_ok  input  1  result qualifying try_valid: 1 = correct code
attempts  output  2  failed-attempt count 0..3, to buzzer driver
unlock  output  1  door/lock actuator enable
locked  output  1  lockout indicator, high when attempts = 3

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, attempts=0, unlock=0, locked=0, absence counter=0, open timer=0. All outputs are registered.
- Absence counter: width $clog2(ABSENT_CYCLES+1). Clears on any cycle with presence=1. Increments while presence=0 and saturates at ABSENT_CYCLES.
- absent_timeout is a single-cycle event, true on the cycle where presence=0 and the counter equals ABSENT_CYCLES-1. It does not re-fire until presence returns to 1.
- Latency: the effect of try_valid or absent_timeout in cycle N is visible on the outputs at N+1.
- IDLE: attempts=0, unlock=0, locked=0. presence=1 moves to ARMED. try_valid is ignored.
- ARMED:
  - try_valid & try_ok: go to OPEN, attempts<=0, unlock<=1, load open timer.
  - try_valid & !try_ok with attempts<2: attempts<=attempts+1, stay in ARMED.
  - try_valid & !try_ok with attempts=2: attempts<=3, locked<=1, go to LOCKED.
  - absent_timeout: go to IDLE, attempts<=0. It takes priority over a simultaneous try_valid.
- OPEN:
  - unlock=1 for exactly OPEN_CYCLES cycles.
  - try_valid and absent_timeout are ignored.
  - When the timer expires: unlock<=0, then go to ARMED if presence=1 on that cycle, else IDLE. attempts stays 0.
- LOCKED:
  - attempts=3 and locked=1 held.
  - All try_valid are ignored, including try_ok=1, so a correct code cannot clear a lockout.
  - Exit only on absent_timeout: go to IDLE, attempts<=0, locked<=0.
- attempts never wraps: there is no transition 3 -> 0 except through absent_timeout or reset.
- Reset asserted mid-operation returns to the reset values immediately, regardless of state or timer contents.
- try_ok is don't-care when try_valid=0.
- Illegal or unused state encodings recover to IDLE on the next clock.

Test Plan:
(Bench uses ABSENT_CYCLES=8, OPEN_CYCLES=4.)
1. Reset then presence=1, three strobes with try_ok=0 spaced 3 cycles apart -> attempts 1, 2, 3, each one cycle after its strobe; locked=1 with the third; unlock stays 0.
2. From LOCKED, strobe try_valid with try_ok=1 -> attempts stays 3, unlock stays 0. Drop presence for 8 cycles -> attempts=0 and locked=0 in the cycle after the 8th; state IDLE.
3. presence=1, one fail (attempts=1), then try_ok=1 strobe -> next cycle attempts=0 and unlock=1 for exactly 4 cycles. A fail strobe during OPEN has no effect. With presence held at 1, the tracker returns to ARMED.
4. ARMED with attempts=2: pulse presence=0 for 7 cycles, then 1 -> no clear, attempts=2. Then drop presence for 8 cycles, with a fail strobe on the timeout cycle -> attempts=0 (timeout wins), not 3.
5. Assert rst_n=0 asynchronously (between clock edges) while in OPEN and while in LOCKED -> unlock, locked and attempts go to 0 without waiting for a clock edge; after release, the tracker starts in IDLE.
